// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch stage. It holds the fetch PC and issues one request at a
// time to a variable-latency instruction memory. Each returned word is
// registered together with its PC and offered to decode through a
// valid/ready handshake. Taken-branch/jump redirects from execute re-steer
// the fetch PC.
//
// Build option: define FETCH_MISALIGN_TRAP_EN to enable the misaligned
// redirect trap. When it is enabled, a redirect whose target has a nonzero
// T[1:0] parks the stage in TRAP until reset. When it is not defined, the
// redirect target is forced to word alignment and misalign_o is tied to 0.
//
// Parameters
//   RESET_PC            fetch address after reset (word aligned)
// Ports
//   clk_i               clock, rising edge
//   rst_n_i             synchronous active-low reset
//   imem_req_o          instruction memory request
//   imem_addr_o         request address; held while imem_req_o until ack
//   imem_ack_i          memory data valid this cycle
//   imem_rdata_i        instruction word returned by memory
//   inst_o              registered instruction to decode
//   pc_o                address of inst_o
//   inst_valid_o        inst_o/pc_o valid
//   inst_ready_i        decode accepts inst_o this cycle
//   redirect_i          taken branch/jump pulse
//   redirect_target_i   new fetch address
//   misalign_o          misaligned redirect trap flag
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | one cycle after reset, no request
// REQ   | request outstanding at fetch_pc
// HOLD  | word registered, waiting for decode to accept it
// FLUSH | abandoned request still outstanding, its data is dropped
// TRAP  | misaligned redirect seen, stage frozen until reset
// ----------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_target_i,
    output logic        misalign_o
);

    localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_HOLD, S_FLUSH, S_TRAP
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_HOLD, S_FLUSH
    } state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] flush_addr_q, flush_addr_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] target;
    logic        redir_en;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_q, misalign_d;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            fetch_pc_q   <= RESET_PC;
            flush_addr_q <= RESET_PC;
            inst_q       <= NOP;
            pc_q         <= RESET_PC;
            valid_q      <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            flush_addr_q <= flush_addr_d;
            inst_q       <= inst_d;
            pc_q         <= pc_d;
            valid_q      <= valid_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q   <= misalign_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        flush_addr_d = flush_addr_q;
        inst_d       = inst_q;
        pc_d         = pc_q;
        valid_d      = valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_d   = misalign_q;
        target       = redirect_target_i;
        redir_en     = redirect_i && (state_q != S_TRAP);
`else
        target       = redirect_target_i & 32'hFFFF_FFFC;
        redir_en     = redirect_i;
`endif

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (imem_ack_i) begin
                    inst_d     = imem_rdata_i;
                    pc_d       = fetch_pc_q;
                    valid_d    = 1'b1;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (inst_ready_i) begin
                    valid_d = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_FLUSH: begin
                if (imem_ack_i) state_d = S_REQ;
            end
            default: state_d = state_q;
        endcase

        // Redirect overrides the normal flow. A word returning in the same
        // cycle is discarded by restoring inst/pc and clearing valid.
        if (redir_en) begin
            inst_d     = inst_q;
            pc_d       = pc_q;
            valid_d    = 1'b0;
            fetch_pc_d = target;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (target[1:0] != 2'b00) begin
                pc_d       = target;
                misalign_d = 1'b1;
                state_d    = S_TRAP;
            end else
`endif
            if (state_q == S_REQ && !imem_ack_i) begin
                flush_addr_d = fetch_pc_q;
                state_d      = S_FLUSH;
            end else if (state_q != S_FLUSH) begin
                state_d = S_REQ;
            end
            // In FLUSH the abandoned request keeps its address, so only
            // fetch_pc moves; the FLUSH ack decision above still applies.
        end
    end

    assign imem_req_o   = (state_q == S_REQ) || (state_q == S_FLUSH);
    assign imem_addr_o  = (state_q == S_FLUSH) ? flush_addr_q : fetch_pc_q;
    assign inst_o       = inst_q;
    assign pc_o         = pc_q;
    assign inst_valid_o = valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign misalign_o   = misalign_q;
`else
    assign misalign_o   = 1'b0;
`endif

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage directly upstream of the immediate generator and decoder. Holds the fetch PC, issues requests to a variable-latency instruction memory, and registers each returned instruction word with its PC. Presents the word to decode with a valid/ready handshake, and accepts taken-branch/jump redirects from execute.

## Interface
- RESET_PC, 32'h0000_0000: fetch address after reset; must be word aligned.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- imem_req  out  1  instruction memory request.
- imem_addr  out  32  word-aligned request address; stable while imem_req=1 until imem_ack.
- imem_ack  in  1  memory data valid this cycle; ignored when imem_req=0.
- imem_rdata  in  32  instruction word, sampled when imem_req & imem_ack.
- inst  out  32  registered instruction to decode/immediate generator.
- pc  out  32  address of inst.
- inst_valid  out  1  inst/pc valid.
- inst_ready  in  1  decode accepts inst this cycle.
- redirect  in  1  taken branch/jump; one-cycle pulse.
- redirect_target  in  32  new fetch address.
- misalign  out  1  misaligned redirect trap (see Configuration).

## Operation
- Internal fetch_pc register; states IDLE, REQ, HOLD, FLUSH, TRAP.
- Reset (rst_n=0 at clk edge): state IDLE, fetch_pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, inst=32'h0000_0013 (NOP), pc=RESET_PC, inst_valid=0, misalign=0.
- IDLE: imem_req=0; next state REQ.
- REQ: imem_req=1, imem_addr=fetch_pc. On imem_ack: inst<=imem_rdata, pc<=fetch_pc, inst_valid<=1, fetch_pc<=fetch_pc+4; next HOLD. No ack: stay.
- HOLD: imem_req=0, inst_valid=1, inst/pc stable. inst_ready=1: inst_valid<=0; next REQ. Otherwise stay.
- FLUSH: imem_req=1, imem_addr = abandoned address; on imem_ack discard data, next REQ (fetch_pc already holds target).
- Redirect (highest priority, any state except TRAP), with target T: fetch_pc<=T, inst_valid<=0.
  - Next state: FLUSH if in REQ without imem_ack; otherwise REQ.
  - In REQ with imem_ack the same cycle, the returned word is discarded.
  - In HOLD with inst_ready the same cycle, the handshake completes (decode takes inst), then the redirect applies.
  - Redirect in FLUSH updates fetch_pc only; stay in FLUSH.
- fetch_pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).

## Timing
- Zero-wait memory (imem_ack in same cycle as imem_req): one instruction per 2 cycles (REQ, HOLD).
- Reset release to first imem_req: 1 cycle (IDLE).
- imem_ack to inst_valid: 1 cycle (registered).
- Redirect to imem_req with target: next cycle, or after FLUSH ack.
- All outputs registered or decoded from state only; no combinational path from inst_ready/redirect to imem_*.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined: redirect with T[1:0]!=0 moves to TRAP and latches pc<=T, misalign<=1, inst_valid<=0, imem_req=0. TRAP is held until reset; any outstanding request is abandoned, and late acks are ignored. A redirect arriving in FLUSH that is misaligned also enters TRAP.
- Not defined: T[1:0] forced to 2'b00 on every redirect; misalign tied 0; TRAP state absent.

## Test plan
- Reset with RESET_PC=32'h100 -> cycle 1 after release: imem_req=1, imem_addr=32'h100; inst_valid=0, inst=32'h13 during reset.
- Zero-wait memory returning 32'h00500093, 32'h00A00113 with inst_ready=1 -> inst_valid pulses with pc 32'h100, 32'h104; new instruction every 2 cycles.
- inst_ready low for 5 cycles in HOLD -> inst/pc/inst_valid unchanged, imem_req=0; accepted on first ready cycle, next request to 32'h108.
- Redirect to 32'h200 while REQ waits 3 cycles for ack -> FLUSH keeps imem_addr=old until ack, data dropped, then imem_addr=32'h200; no inst_valid for the dropped word.
- RESET_PC=32'hFFFF_FFFC, one fetch -> next imem_addr=32'h0.
- Redirect to 32'h202: with FETCH_MISALIGN_TRAP_EN -> misalign=1, pc=32'h202, no further imem_req until reset. Without it -> fetch at 32'h200, misalign=0.
